// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_ctrl_pkg : shared encodings and defaults for the mul/div ctrl |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_DIV  = 2'd1,
    OP_MFHI = 2'd2,
    OP_MFLO = 2'd3
  } op_sel_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  localparam int MULT_LAT_DEF = 34;
  localparam int DIV_LAT_DEF  = 34;
  localparam int CNT_W_DEF    = 6;

  // A divide by zero is answered with a flag and never reaches the divider.
  function automatic logic is_launch(input op_sel_e op, input logic [31:0] rt);
    return (op == OP_MULT) || ((op == OP_DIV) && (rt != 32'd0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_ctrl_if : CPU-side request/response bundle of the controller  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic        op_valid;
  op_sel_e     op_sel;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        div_zero;

  modport master (
    output op_valid, op_sel, rs_data, rt_data,
    input  stall, rd_valid, rd_data, div_zero
  );

  modport slave (
    input  op_valid, op_sel, rs_data, rt_data,
    output stall, rd_valid, rd_data, div_zero
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl_latency_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | latency_counter : loadable down-counter with a zero flag             |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module latency_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_ctrl : launches MULT/DIV, waits out latency, owns HI/LO       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  muldiv_ctrl_if.slave cpu,
  output logic         unit_reset,
  output logic         mult_start,
  output logic         div_start,
  output logic [31:0]  unit_a,
  output logic [31:0]  unit_b,
  input  logic [31:0]  mult_hi,
  input  logic [31:0]  mult_lo,
  input  logic [31:0]  div_hi,
  input  logic [31:0]  div_lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  state_e      state_q,    state_d;
  logic        is_div_q,   is_div_d;
  logic [31:0] hi_q,       hi_d;
  logic [31:0] lo_q,       lo_d;
  logic [31:0] unit_a_q,   unit_a_d;
  logic [31:0] unit_b_q,   unit_b_d;
  logic [31:0] rd_data_q,  rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        div_zero_q, div_zero_d;
  logic        abort_q,    abort_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  latency_counter #(
    .CNT_W (CNT_W)
  ) u_latency_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (flush),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    is_div_d     = is_div_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    unit_a_d     = unit_a_q;
    unit_b_d     = unit_b_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    div_zero_d   = 1'b0;
    abort_d      = flush;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = is_div_q ? DIV_LOAD : MULT_LOAD;
    mult_start   = 1'b0;
    div_start    = 1'b0;

    // Squash wins over everything: no accept, no start pulse, no capture.
    if (reset || flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cpu.op_valid) begin
            unique case (cpu.op_sel)
              OP_MULT, OP_DIV: begin
                if (is_launch(cpu.op_sel, cpu.rt_data)) begin
                  unit_a_d = cpu.rs_data;
                  unit_b_d = cpu.rt_data;
                  is_div_d = (cpu.op_sel == OP_DIV);
                  state_d  = S_START;
                end else begin
                  div_zero_d = 1'b1;
                end
              end
              OP_MFHI: begin
                rd_valid_d = 1'b1;
                rd_data_d  = hi_q;
              end
              OP_MFLO: begin
                rd_valid_d = 1'b1;
                rd_data_d  = lo_q;
              end
              default: ;
            endcase
          end
        end
        S_START: begin
          mult_start = ~is_div_q;
          div_start  = is_div_q;
          cnt_load   = 1'b1;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_zero) begin
            state_d = S_CAPTURE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        S_CAPTURE: begin
          hi_d    = is_div_q ? div_hi : mult_hi;
          lo_d    = is_div_q ? div_lo : mult_lo;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      unit_a_q   <= '0;
      unit_b_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      div_zero_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      unit_a_q   <= unit_a_d;
      unit_b_q   <= unit_b_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      div_zero_q <= div_zero_d;
      abort_q    <= abort_d;
    end
  end

  // The accepting IDLE cycle already stalls so the CPU holds its operands.
  assign cpu.stall    = ~reset & cpu.op_valid &
                        ((state_q != S_IDLE) | is_launch(cpu.op_sel, cpu.rt_data));
  assign cpu.rd_valid = rd_valid_q;
  assign cpu.rd_data  = rd_data_q;
  assign cpu.div_zero = div_zero_q;
  assign unit_reset   = reset | abort_q;
  assign unit_a       = unit_a_q;
  assign unit_b       = unit_b_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_ctrl : directed bench with behavioural MULT/DIV units      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MULT_LAT = 34;
  localparam int DIV_LAT  = 34;
  localparam int FULL_WAIT = MULT_LAT + 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        unit_reset, mult_start, div_start;
  logic [31:0] unit_a, unit_b;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

  int errors = 0;
  int checks = 0;
  int n_mult = 0;
  int n_div  = 0;
  int n_ur   = 0;

  muldiv_ctrl_if cpu ();

  muldiv_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (6)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .cpu        (cpu),
    .unit_reset (unit_reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .div_hi     (div_hi),
    .div_lo     (div_lo)
  );

  always #5 clock = ~clock;

  // Unit models: garbage until the final result, which is valid from the
  // edge MULT_LAT/DIV_LAT edges after the start pulse is sampled.
  logic [63:0] m_prod;
  int          m_cnt = -1;
  always @(posedge clock) begin
    if (unit_reset) begin
      m_cnt   <= -1;
      mult_hi <= 32'hDEADBEEF;
      mult_lo <= 32'hDEADBEEF;
    end else if (mult_start) begin
      m_prod  <= {{32{unit_a[31]}}, unit_a} * {{32{unit_b[31]}}, unit_b};
      m_cnt   <= MULT_LAT - 2;
      mult_hi <= 32'hBAADF00D;
      mult_lo <= 32'hBAADF00D;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 0) begin
      mult_hi <= m_prod[63:32];
      mult_lo <= m_prod[31:0];
      m_cnt   <= -1;
    end
  end

  logic [31:0] d_q, d_r;
  int          d_cnt = -1;
  always @(posedge clock) begin
    if (unit_reset) begin
      d_cnt  <= -1;
      div_hi <= 32'hDEADBEEF;
      div_lo <= 32'hDEADBEEF;
    end else if (div_start) begin
      d_q    <= (unit_b != 0) ? unit_a / unit_b : 32'hFFFFFFFF;
      d_r    <= (unit_b != 0) ? unit_a % unit_b : unit_a;
      d_cnt  <= DIV_LAT - 2;
      div_hi <= 32'hBAADF00D;
      div_lo <= 32'hBAADF00D;
    end else if (d_cnt > 0) begin
      d_cnt <= d_cnt - 1;
    end else if (d_cnt == 0) begin
      div_hi <= d_r;
      div_lo <= d_q;
      d_cnt  <= -1;
    end
  end

  always @(posedge clock) begin
    if (mult_start) n_mult <= n_mult + 1;
    if (div_start)  n_div  <= n_div + 1;
    if (unit_reset) n_ur   <= n_ur + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input op_sel_e sel, input logic [31:0] a, input logic [31:0] b);
    cpu.op_valid = 1'b1;
    cpu.op_sel   = sel;
    cpu.rs_data  = a;
    cpu.rt_data  = b;
    tick();
    cpu.op_valid = 1'b0;
  endtask

  // Holds an MFHI/MFLO request until accepted; reports stalled cycles.
  task automatic read_reg(input op_sel_e sel, output logic [31:0] data,
                          output logic valid, output int waited);
    cpu.op_valid = 1'b1;
    cpu.op_sel   = sel;
    #1;
    waited = 0;
    while (cpu.stall === 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    tick();
    cpu.op_valid = 1'b0;
    valid = cpu.rd_valid;
    data  = cpu.rd_data;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        v;
    int          w;
    reset = 1'b1;
    flush = 1'b0;
    cpu.op_valid = 1'b1;
    cpu.op_sel   = OP_MULT;
    cpu.rs_data  = 32'd1;
    cpu.rt_data  = 32'd1;
    tick();
    tick();
    checks++;
    if (cpu.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", cpu.stall); end
    checks++;
    if ({cpu.rd_valid, cpu.div_zero, mult_start, div_start} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000", {cpu.rd_valid, cpu.div_zero, mult_start, div_start});
    end
    checks++;
    if (cpu.rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", cpu.rd_data); end
    checks++;
    if (unit_reset !== 1'b1) begin errors++; $display("FAIL reset_unit_reset: got %b expected 1", unit_reset); end
    checks++;
    if ({unit_a, unit_b} !== 64'd0) begin errors++; $display("FAIL reset_operands: got %h expected 0", {unit_a, unit_b}); end
    cpu.op_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (unit_reset !== 1'b0) begin errors++; $display("FAIL reset_release: got %b expected 0", unit_reset); end
    read_reg(OP_MFHI, d, v, w);
    checks++;
    if (v !== 1'b1 || d !== 32'd0 || w != 0) begin
      errors++; $display("FAIL reset_mfhi: got v=%b d=%h wait=%0d expected v=1 d=0 wait=0", v, d, w);
    end
  endtask

  task automatic test_mult_neg;
    logic [31:0] d;
    logic        v;
    int          w;
    int          n0;
    n0 = n_mult;
    cpu.op_valid = 1'b1;
    cpu.op_sel   = OP_MULT;
    cpu.rs_data  = 32'd7;
    cpu.rt_data  = 32'hFFFFFFFD;
    #1;
    checks++;
    if (cpu.stall !== 1'b1) begin errors++; $display("FAIL mult_accept_stall: got %b expected 1", cpu.stall); end
    tick();
    checks++;
    if (mult_start !== 1'b1 || div_start !== 1'b0) begin
      errors++; $display("FAIL mult_start_pulse: got m=%b d=%b expected m=1 d=0", mult_start, div_start);
    end
    checks++;
    if (unit_a !== 32'd7 || unit_b !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL mult_operands: got %h/%h expected 00000007/fffffffd", unit_a, unit_b);
    end
    read_reg(OP_MFLO, d, v, w);
    checks++;
    if (w != FULL_WAIT) begin errors++; $display("FAIL mult_stall_cycles: got %0d expected %0d", w, FULL_WAIT); end
    checks++;
    if (v !== 1'b1 || d !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo: got v=%b %h expected v=1 ffffffeb", v, d); end
    read_reg(OP_MFHI, d, v, w);
    checks++;
    if (v !== 1'b1 || d !== 32'hFFFFFFFF || w != 0) begin
      errors++; $display("FAIL mult_neg_hi: got v=%b %h wait=%0d expected v=1 ffffffff wait=0", v, d, w);
    end
    tick();
    checks++;
    if (cpu.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b expected 0", cpu.rd_valid); end
    checks++;
    if (n_mult - n0 != 1) begin errors++; $display("FAIL mult_neg_starts: got %0d expected 1", n_mult - n0); end
  endtask

  task automatic test_mult_min;
    logic [31:0] d;
    logic        v;
    int          w;
    int          n0;
    n0 = n_mult;
    launch(OP_MULT, 32'h80000000, 32'h80000000);
    cpu.rs_data = 32'h12345678;
    cpu.rt_data = 32'h00000009;
    tick();
    tick();
    checks++;
    if (unit_a !== 32'h80000000 || unit_b !== 32'h80000000) begin
      errors++; $display("FAIL operands_held: got %h/%h expected 80000000/80000000", unit_a, unit_b);
    end
    read_reg(OP_MFHI, d, v, w);
    checks++;
    if (v !== 1'b1 || d !== 32'h40000000 || w != FULL_WAIT - 2) begin
      errors++; $display("FAIL mult_min_hi: got v=%b %h wait=%0d expected v=1 40000000 wait=%0d", v, d, w, FULL_WAIT - 2);
    end
    read_reg(OP_MFLO, d, v, w);
    checks++;
    if (v !== 1'b1 || d !== 32'h00000000) begin errors++; $display("FAIL mult_min_lo: got v=%b %h expected v=1 0", v, d); end
    checks++;
    if (n_mult - n0 != 1) begin errors++; $display("FAIL mult_min_starts: got %0d expected 1", n_mult - n0); end
  endtask

  task automatic test_div_zero;
    logic [31:0] d;
    logic        v;
    int          w;
    int          n0;
    n0 = n_div;
    cpu.op_valid = 1'b1;
    cpu.op_sel   = OP_DIV;
    cpu.rs_data  = 32'd5;
    cpu.rt_data  = 32'd0;
    #1;
    checks++;
    if (cpu.stall !== 1'b0) begin errors++; $display("FAIL divzero_stall: got %b expected 0", cpu.stall); end
    checks++;
    if (cpu.div_zero !== 1'b0) begin errors++; $display("FAIL divzero_early: got %b expected 0", cpu.div_zero); end
    tick();
    cpu.op_valid = 1'b0;
    checks++;
    if (cpu.div_zero !== 1'b1) begin errors++; $display("FAIL divzero_pulse: got %b expected 1", cpu.div_zero); end
    tick();
    checks++;
    if (cpu.div_zero !== 1'b0) begin errors++; $display("FAIL divzero_width: got %b expected 0", cpu.div_zero); end
    checks++;
    if (n_div != n0 || div_start !== 1'b0) begin errors++; $display("FAIL divzero_no_start: got %0d starts expected 0", n_div - n0); end
    read_reg(OP_MFHI, d, v, w);
    checks++;
    if (v !== 1'b1 || d !== 32'h40000000 || w != 0) begin
      errors++; $display("FAIL divzero_hi: got v=%b %h wait=%0d expected v=1 40000000 wait=0", v, d, w);
    end
    read_reg(OP_MFLO, d, v, w);
    checks++;
    if (d !== 32'h00000000) begin errors++; $display("FAIL divzero_lo: got %h expected 0", d); end
  endtask

  task automatic test_div;
    logic [31:0] d;
    logic        v;
    int          w;
    int          nm0, nd0;
    nm0 = n_mult;
    nd0 = n_div;
    launch(OP_DIV, 32'd100, 32'd7);
    read_reg(OP_MFHI, d, v, w);
    checks++;
    if (v !== 1'b1 || d !== 32'd2 || w != FULL_WAIT) begin
      errors++; $display("FAIL div_hi: got v=%b %h wait=%0d expected v=1 2 wait=%0d", v, d, w, FULL_WAIT);
    end
    read_reg(OP_MFLO, d, v, w);
    checks++;
    if (v !== 1'b1 || d !== 32'd14) begin errors++; $display("FAIL div_lo: got v=%b %h expected v=1 e", v, d); end
    checks++;
    if (n_div - nd0 != 1 || n_mult != nm0) begin
      errors++; $display("FAIL div_starts: got div=%0d mult=%0d expected div=1 mult=0", n_div - nd0, n_mult - nm0);
    end
  endtask

  task automatic test_flush;
    logic [31:0] d;
    logic        v;
    int          w;
    int          nm0, nu0;
    nm0 = n_mult;
    launch(OP_MULT, 32'd5, 32'd5);
    for (int i = 0; i < 10; i++) tick();
    nu0 = n_ur;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (unit_reset !== 1'b1) begin errors++; $display("FAIL flush_unit_reset: got %b expected 1", unit_reset); end
    tick();
    checks++;
    if (unit_reset !== 1'b0) begin errors++; $display("FAIL flush_unit_reset_width: got %b expected 0", unit_reset); end
    checks++;
    if (n_ur - nu0 != 1) begin errors++; $display("FAIL flush_unit_reset_count: got %0d expected 1", n_ur - nu0); end
    read_reg(OP_MFLO, d, v, w);
    checks++;
    if (v !== 1'b1 || d !== 32'd14 || w != 0) begin
      errors++; $display("FAIL flush_lo: got v=%b %h wait=%0d expected v=1 e wait=0", v, d, w);
    end
    for (int i = 0; i < 40; i++) tick();
    read_reg(OP_MFHI, d, v, w);
    checks++;
    if (d !== 32'd2 || n_mult - nm0 != 1) begin
      errors++; $display("FAIL flush_no_capture: got hi=%h starts=%0d expected hi=2 starts=1", d, n_mult - nm0);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        v;
    int          w;
    launch(OP_MULT, 32'd3, 32'd4);
    read_reg(OP_MFLO, d, v, w);
    checks++;
    if (v !== 1'b1 || d !== 32'd12 || w != FULL_WAIT) begin
      errors++; $display("FAIL mult_3x4: got v=%b %h wait=%0d expected v=1 c wait=%0d", v, d, w, FULL_WAIT);
    end
    launch(OP_MULT, 32'd3, 32'd4);
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (unit_reset !== 1'b1) begin errors++; $display("FAIL midreset_unit_reset: got %b expected 1", unit_reset); end
    reset = 1'b0;
    cpu.op_valid = 1'b1;
    cpu.op_sel   = OP_MFLO;
    #1;
    checks++;
    if (cpu.stall !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b expected 0", cpu.stall); end
    read_reg(OP_MFLO, d, v, w);
    checks++;
    if (v !== 1'b1 || d !== 32'd0 || w != 0) begin
      errors++; $display("FAIL midreset_lo: got v=%b %h wait=%0d expected v=1 0 wait=0", v, d, w);
    end
    read_reg(OP_MFHI, d, v, w);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL midreset_hi: got %h expected 0", d); end
  endtask

  initial begin
    cpu.op_valid = 1'b0;
    cpu.op_sel   = OP_MULT;
    cpu.rs_data  = '0;
    cpu.rt_data  = '0;
    test_reset();
    test_mult_neg();
    test_mult_min();
    test_div_zero();
    test_div();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
